// File: rtl/keypad_pkg.sv
// Shared types and tables for the 4x4 hex keypad scanner: FSM state enum,
// row/column to hex key map and the row-pattern encoder.
package keypad_pkg;

    typedef enum logic [1:0] {
        StScan,
        StPressDb,
        StHold,
        StRelDb
    } state_e;

    // Indexed as KeyMap[row][col]; rows listed 3..0, columns 3..0 within a row.
    localparam logic [3:0][3:0][3:0] KeyMap = {
        {4'hD, 4'hF, 4'h0, 4'hE},
        {4'hC, 4'h9, 4'h8, 4'h7},
        {4'hB, 4'h6, 4'h5, 4'h4},
        {4'hA, 4'h3, 4'h2, 4'h1}
    };

    // Lowest set row wins when several rows are closed.
    function automatic logic [1:0] row_encode(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/debounce_ctr.sv
// Saturating debounce counter with synchronous clear and enable; done_o flags
// the enabled cycle in which the count reaches DEBOUNCE_CYCLES.
module debounce_ctr #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 5
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != CNT_W'(DEBOUNCE_CYCLES))) begin
            count_d = count_q + 1'b1;
        end
    end

    assign done_o = en_i && !clr_i && (count_q == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// Column-driving 4x4 keypad scanner with press/release debounce and a one-cycle
// key strobe. Define KEYPAD_GHOST_REJECT_EN to reject samples with >1 row closed.
module keypad_scan #(
    parameter int unsigned SCAN_CYCLES     = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] rows_i,
    output logic [3:0] cols_o,
    output logic [3:0] key_code_o,
    output logic       key_valid_o,
    output logic       key_held_o
);
    import keypad_pkg::*;

    localparam int unsigned MaxCycles = (SCAN_CYCLES > DEBOUNCE_CYCLES) ?
                                        SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

    state_e           state_q, state_d;
    logic [1:0]       col_q, col_d;
    logic [3:0]       cols_q, cols_d;
    logic [CntW-1:0]  dwell_q, dwell_d;
    logic [3:0]       pat_q, pat_d;
    logic [3:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             held_q, held_d;

    logic             ctr_clr, ctr_en, ctr_done;
    logic             rows_hit, rows_match;

`ifdef KEYPAD_GHOST_REJECT_EN
    logic ghost;
    assign ghost      = $countones(rows_i) > 1;
    assign rows_hit   = (rows_i != 4'h0) && !ghost;
    assign rows_match = (rows_i == pat_q) && !ghost;
`else
    assign rows_hit   = rows_i != 4'h0;
    assign rows_match = rows_i == pat_q;
`endif

    // The sample cycle itself counts as the first stable cycle of a press or
    // release, so the counter is enabled on the transition into each DB state.
    debounce_ctr #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CntW)
    ) u_debounce_ctr (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (ctr_clr),
        .en_i  (ctr_en),
        .done_o(ctr_done)
    );

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        dwell_d = dwell_q;
        pat_d   = pat_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;
        ctr_clr = 1'b1;
        ctr_en  = 1'b0;

        unique case (state_q)
            StScan: begin
                if (dwell_q == CntW'(SCAN_CYCLES - 1)) begin
                    dwell_d = '0;
                    if (rows_hit) begin
                        pat_d   = rows_i;
                        state_d = StPressDb;
                        ctr_clr = 1'b0;
                        ctr_en  = 1'b1;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            StPressDb: begin
                if (rows_match) begin
                    ctr_clr = 1'b0;
                    ctr_en  = 1'b1;
                    if (ctr_done) begin
                        code_d  = KeyMap[row_encode(pat_q)][col_q];
                        valid_d = 1'b1;
                        held_d  = 1'b1;
                        state_d = StHold;
                    end
                end else begin
                    dwell_d = '0;
                    state_d = StScan;
                end
            end
            StHold: begin
                if (rows_i == 4'h0) begin
                    ctr_clr = 1'b0;
                    ctr_en  = 1'b1;
                    state_d = StRelDb;
                end
            end
            StRelDb: begin
                if (rows_i == 4'h0) begin
                    ctr_clr = 1'b0;
                    ctr_en  = 1'b1;
                    if (ctr_done) begin
                        held_d  = 1'b0;
                        col_d   = col_q + 2'd1;
                        dwell_d = '0;
                        state_d = StScan;
                    end
                end else begin
                    state_d = StHold;
                end
            end
            default: state_d = StScan;
        endcase

        cols_d = 4'b0001 << col_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StScan;
            col_q   <= 2'd0;
            cols_q  <= 4'b0001;
            dwell_q <= '0;
            pat_q   <= 4'h0;
            code_q  <= 4'h0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            cols_q  <= cols_d;
            dwell_q <= dwell_d;
            pat_q   <= pat_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    assign cols_o      = cols_q;
    assign key_code_o  = code_q;
    assign key_valid_o = valid_q;
    assign key_held_o  = held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan: a keypad model drives rows from the driven
// column, an event-level reference predicts columns, strobes, codes and holds.
module tb_keypad_scan;

    localparam int Scan = 4;
    localparam int Db   = 8;
    localparam int NMax = 256;

    logic       clk;
    logic       rst_ni;
    logic [3:0] rows_i;
    logic [3:0] cols_o;
    logic [3:0] key_code_o;
    logic       key_valid_o;
    logic       key_held_o;

    keypad_scan #(
        .SCAN_CYCLES    (Scan),
        .DEBOUNCE_CYCLES(Db)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .rows_i     (rows_i),
        .cols_o     (cols_o),
        .key_code_o (key_code_o),
        .key_valid_o(key_valid_o),
        .key_held_o (key_held_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] code;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        ev;
    int         exp_col  [NMax];
    bit         exp_held [NMax];
    logic [3:0] exp_code [NMax];
    int         keymap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11},
                                  '{7, 8, 9, 12}, '{14, 0, 15, 13}};

    // Scenario: key(s) sc_mask on column sc_col closed over [sc_p, sc_e),
    // bouncing 3 on / 3 off until sc_b, plus an optional closure glitch.
    int         sc_col, sc_p, sc_b, sc_e, sc_g, sc_glen;
    logic [3:0] sc_mask;

    int cyc;
    int n_checks;
    int n_pass;
    int model_accept;
    bit running;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    endtask

    function automatic logic [3:0] rows_at(input int t, input int col);
        bit closed;
        closed = (t >= sc_p && t < sc_e && (t >= sc_b || ((t - sc_p) / 3) % 2 == 0)) ||
                 (t >= sc_g && t < sc_g + sc_glen);
        return (col == sc_col && closed) ? sc_mask : 4'h0;
    endfunction

    function automatic logic [3:0] eff(input logic [3:0] p);
`ifdef KEYPAD_GHOST_REJECT_EN
        if ($countones(p) > 1) return 4'h0;
`endif
        return p;
    endfunction

    function automatic int low_row(input logic [3:0] p);
        for (int i = 0; i < 4; i++) if (p[i]) return i;
        return 0;
    endfunction

    task automatic set_sc(input int col, input logic [3:0] mask, input int p, input int b,
                          input int e, input int g, input int glen);
        sc_col = col; sc_mask = mask; sc_p = p; sc_b = b; sc_e = e; sc_g = g; sc_glen = glen;
    endtask

    // Walk the scan timeline event by event: dwell windows, press windows,
    // hold and release windows, filling per-cycle expectations.
    task automatic build_model(input int n);
        int t, col, sample, abort_t, a, h, bad, fall, stop;
        logic [3:0] p, code;
        exp_q.delete();
        for (int i = 0; i < NMax; i++) begin
            exp_col[i] = 0; exp_held[i] = 1'b0; exp_code[i] = 4'h0;
        end
        t = 0; col = 0; code = 4'h0; model_accept = -1;
        while (t < n) begin
            sample = t + Scan - 1;
            for (int i = t; i <= sample && i < n; i++) begin
                exp_col[i] = col; exp_code[i] = code;
            end
            if (sample >= n) break;
            p = eff(rows_at(sample, col));
            if (p == 4'h0) begin
                col = (col + 1) % 4; t = sample + 1;
                continue;
            end
            abort_t = -1;
            for (int k = 1; k < Db && abort_t < 0; k++) begin
                if (sample + k < n) begin
                    exp_col[sample + k] = col; exp_code[sample + k] = code;
                end
                if (rows_at(sample + k, col) != p) abort_t = sample + k;
            end
            if (abort_t >= 0) begin
                t = abort_t + 1;
                continue;
            end
            a = sample + Db;
            code = 4'(keymap[low_row(p)][col]);
            if (model_accept < 0) model_accept = a;
            if (a < n) exp_q.push_back('{a, code});
            h = a; fall = -1;
            while (fall < 0 && h < n) begin
                if (rows_at(h, col) != 4'h0) h++;
                else begin
                    bad = -1;
                    for (int k = 1; k < Db && bad < 0; k++)
                        if (rows_at(h + k, col) != 4'h0) bad = h + k;
                    if (bad >= 0) h = bad + 1;
                    else fall = h + Db;
                end
            end
            stop = (fall < 0) ? n : fall;
            for (int i = a; i < stop && i < n; i++) begin
                exp_col[i] = col; exp_held[i] = 1'b1; exp_code[i] = code;
            end
            if (fall < 0) break;
            col = (col + 1) % 4; t = fall;
        end
    endtask

    task automatic drive();
        int c;
        case (cols_o)
            4'b0001: c = 0;
            4'b0010: c = 1;
            4'b0100: c = 2;
            4'b1000: c = 3;
            default: c = -1;
        endcase
        rows_i = rows_at(cyc, c);
    endtask

    task automatic run(input int n);
        build_model(n);
        running = 1'b0;
        rst_ni  = 1'b0;
        rows_i  = 4'h0;
        repeat (2) @(posedge clk);
        #2;
        rst_ni = 1'b1;
        cyc    = 0;
        drive();
        running = 1'b1;
        repeat (n - 1) begin
            @(posedge clk);
            cyc++;
            #1 drive();
        end
        @(negedge clk);
        #1 running = 1'b0;
        chk("missed_valid", exp_q.size(), 0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (running && cyc < NMax) begin
            chk("cols", cols_o, 32'(1) << exp_col[cyc]);
            chk("key_held", key_held_o, exp_held[cyc]);
            chk("key_code", key_code_o, exp_code[cyc]);
            if (key_valid_o) begin
                if (exp_q.size() == 0) chk("spurious_valid", cyc, -1);
                else begin
                    ev = exp_q.pop_front();
                    chk("valid_cycle", cyc, ev.cyc);
                    chk("valid_code", key_code_o, ev.code);
                end
            end
        end
    end

    initial begin
        int p, b, e, g, gl, acc;
        n_checks = 0; n_pass = 0; running = 1'b0; cyc = 0;
        rst_ni = 1'b0; rows_i = 4'h0;

        set_sc(0, 4'h0, 1000, 1000, 1000, -1, 0);
        run(80);

        p = $urandom_range(0, 20);
        set_sc(2, 4'b0010, p, p, p + 60, -1, 0);
        run(160);

        p = $urandom_range(0, 20);
        set_sc(2, 4'b0010, p, p + 12 + $urandom_range(0, 6), p + 70, -1, 0);
        run(200);

        p = $urandom_range(0, 20);
        set_sc(2, 4'b0010, p, p, p + 60, p + 65, 2);
        run(200);

        set_sc(0, 4'b0101, 2, 2, 80, -1, 0);
        run(160);

        for (int i = 0; i < 12; i++) begin
            p = $urandom_range(0, 40);
            b = p + $urandom_range(0, 15);
            e = b + $urandom_range(5, 60);
            if ($urandom_range(0, 1) == 1) begin
                g = e + $urandom_range(1, 8); gl = $urandom_range(1, 3);
            end else begin
                g = -1; gl = 0;
            end
            set_sc($urandom_range(0, 3), 4'($urandom_range(1, 15)), p, b, e, g, gl);
            run(220);
        end

        // Asynchronous reset while a key is held.
        set_sc(2, 4'b0010, 3, 3, 200, -1, 0);
        build_model(200);
        acc = model_accept;
        exp_q.delete();
        run(acc + 6);
        chk("held_before_rst", key_held_o, 1);
        chk("code_before_rst", key_code_o, 4'h6);
        #1 rst_ni = 1'b0;
        #1;
        chk("rst_cols", cols_o, 4'b0001);
        chk("rst_key_code", key_code_o, 4'h0);
        chk("rst_key_held", key_held_o, 0);
        chk("rst_key_valid", key_valid_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Column-driving scanner for the 4x4 hex keypad. Drives one column at a time and reads the row lines, which arrive through the existing two-flop `sync` block. Debounces press and release, then emits a single-cycle strobe with the 4-bit hex code of the pressed key. It sits between the keypad pins and the display/key-history logic.

## Interface
- `SCAN_CYCLES`, 4: dwell per column in clk cycles; must be ≥4 to cover the synchronizer latency.
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required for press and for release.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `rows` in 4: row lines, already synchronized, active-high (1 = key closed on the driven column).
- `cols` out 4: one-hot, active-high column drive.
- `key_code` out 4: hex code of the last accepted key; holds until the next accept.
- `key_valid` out 1: one-cycle strobe when a key is accepted.
- `key_held` out 1: high from accept until release is debounced.

## Operation
- Reset values: `cols`=4'b0001, `key_code`=4'h0, `key_valid`=0, `key_held`=0, state SCAN, counters 0.
- SCAN
  - Drive column c for `SCAN_CYCLES` cycles.
  - Sample `rows` only on the last dwell cycle.
  - If `rows`==0, advance to c+1, wrapping 3→0.
  - If `rows`≠0, capture (c, row pattern) and go to PRESS_DB; `cols` freezes at c.
- PRESS_DB
  - Count cycles while `rows` equals the captured pattern.
  - Any mismatch: return to SCAN, restarting the dwell on column c.
  - Count reaches `DEBOUNCE_CYCLES`: load `key_code`, pulse `key_valid`, go to HOLD.
- HOLD
  - `cols` stays at c; `key_held`=1.
  - When `rows`==0, go to REL_DB.
  - Pattern changes while still nonzero: stay in HOLD. No second key is accepted and there is no auto-repeat.
- REL_DB
  - Count consecutive cycles with `rows`==0.
  - Any nonzero value: back to HOLD.
  - Count reaches `DEBOUNCE_CYCLES`: `key_held`=0, go to SCAN on column c+1.
- Multiple row bits set on one column: the lowest-index row wins (see Configuration for the alternative).
- Key map, row r / col c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- Counter widths: $clog2(max(SCAN_CYCLES, DEBOUNCE_CYCLES))+1. Counters saturate and never wrap.

## Timing
- Column c is asserted at cycle t.
  - Sample point is t+SCAN_CYCLES−1.
  - With no key, the next column is asserted at t+SCAN_CYCLES.
- Press sampled at cycle S, with the pattern stable S..S+DEBOUNCE_CYCLES−1:
  - `key_valid`=1 at exactly S+DEBOUNCE_CYCLES.
  - `key_code` is valid in that same cycle.
  - `key_held` rises in that same cycle.
- Release: rows first read 0 at cycle R (entering REL_DB), stays 0 → `key_held` falls at R+DEBOUNCE_CYCLES, and the next column is driven in that same cycle.
- Each debounce counter restarts from 0 on every re-entry into its state.
- `reset` asserted mid-operation returns every output to its reset value asynchronously. After deassertion, scanning restarts at column 0 on the first clk edge.
- `key_valid` is never high for two consecutive cycles.

## Configuration
- Macro `KEYPAD_GHOST_REJECT_EN`.
- Defined:
  - A sample with more than one `rows` bit set is treated as no press; scanning continues.
  - Popcount>1 during PRESS_DB aborts to SCAN.
- Undefined: lowest-index row priority as described in Operation; no popcount logic is synthesized.

## Structure
- Package `keypad_pkg` holds:
  - the state enum (SCAN, PRESS_DB, HOLD, REL_DB);
  - the 4x4 key-map constant array;
  - the `row_encode` function (one-hot/priority → index).
- One sub-module, `debounce_ctr`: saturating counter with clear and enable, and a `done` flag at `DEBOUNCE_CYCLES`. It is shared by PRESS_DB and REL_DB.
- The `sync` instance stays outside this block, at the top level.

## Test plan
Bench parameters: `SCAN_CYCLES`=4, `DEBOUNCE_CYCLES`=8.
- Idle after reset: `cols` sequence 0001,0010,0100,1000,0001, each held 4 cycles; `key_valid` never rises.
- Clean press of key "6" (row1 while col2 active), held 40 cycles: one `key_valid` pulse with `key_code`=4'h6 exactly 8 cycles after the sample point; `cols` frozen at 0100.
- Bouncy press, rows toggling 0010/0000 every 3 cycles before settling: no `key_valid` until 8 stable cycles have elapsed; exactly one pulse.
- Release with a 2-cycle glitch at cycle 5 of REL_DB: `key_held` stays 1, counter restarts, `key_held` falls 8 cycles after the glitch ends, then `cols` goes to 1000.
- Two keys on col0, rows 0b0101:
  - Macro undefined: `key_code`=4'h1.
  - Macro defined: no `key_valid`, scanning continues.
- `reset` pulled low in HOLD: `cols`=0001, `key_code`=0, `key_held`=0 immediately, without waiting for a clk edge.
